// File: rtl/csr_tohost_fifo.sv
// Captures EX-stage writes to the tohost CSR into a FIFO and drains them to the host over valid/ready.
// Optional per-entry cycle timestamps are enabled with `define CSR_TOHOST_TIMESTAMP_EN.
module csr_tohost_fifo #(
  parameter int          DWIDTH      = 32,
  parameter int          DEPTH       = 8,
  parameter logic [11:0] TOHOST_ADDR = 12'h51E
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     csr_we,
  input  logic [11:0]              csr_addr,
  input  logic [DWIDTH-1:0]        csr_wdata,
  output logic                     fifo_full,
  output logic                     host_valid,
  input  logic                     host_ready,
  output logic [DWIDTH-1:0]        host_data,
`ifdef CSR_TOHOST_TIMESTAMP_EN
  output logic [31:0]              host_ts,
`endif
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              push, pop, isFull, accept, drop;

  // A pop in the same cycle frees a slot, so a push at full is still accepted then.
  always_comb begin
    push       = csr_we && (csr_addr == TOHOST_ADDR);
    pop        = (count_q != '0) && host_ready;
    isFull     = (count_q == CW'(DEPTH));
    accept     = push && (!isFull || pop);
    drop       = push && isFull && !pop;
    wrPtr_d    = accept ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d    = pop ? rdPtr_q + AW'(1) : rdPtr_q;
    count_d    = count_q + CW'(accept) - CW'(pop);
    full_d     = (count_d == CW'(DEPTH));
    overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (accept) begin
      mem_q[wrPtr_q] <= csr_wdata;
    end
  end

`ifdef CSR_TOHOST_TIMESTAMP_EN
  logic [31:0] tsCnt_q;
  logic [31:0] tsMem_q [DEPTH];

  // The stamp is the counter value at the accepting edge, before it increments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tsCnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) tsMem_q[i] <= '0;
    end else begin
      tsCnt_q <= tsCnt_q + 32'd1;
      if (accept) tsMem_q[wrPtr_q] <= tsCnt_q;
    end
  end

  assign host_ts = tsMem_q[rdPtr_q];
`endif

  assign fifo_full  = full_q;
  assign host_valid = (count_q != '0);
  assign host_data  = mem_q[rdPtr_q];
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule
